ddr2_read_capture_fifo: RTL and testbench

Parametrised DDR2 read-data capture buffer. Each `listen` pulse starts capture of one burst of BURST_LEN words from `din`, one word per `clk`, after a programmable delay. Completed bursts are queued in a ring of NUM_SLOTS burst slots and drained in order over a valid/ready stream with a per-burst `last` marker. It sits between the PHY read-data path and the controller's read-return logic. It adds gapless back-to-back bursts, queuing, drop detection and flush.

---
 rtl/ddr2_read_capture_fifo_if.sv | 24 ++
 rtl/ddr2_read_capture_fifo.sv | 173 +++++++++++++++++
 tb/tb_ddr2_read_capture_fifo.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_read_capture_fifo_if.sv
// Read-return stream of the DDR2 capture buffer: head word, valid/ready
// handshake and the end-of-burst marker.
interface ddr2_read_capture_fifo_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );
endinterface

// File: rtl/ddr2_read_capture_fifo.sv
// DDR2 read-data capture buffer. A listen pulse captures one burst of
// BURST_LEN words from din after CAP_DELAY idle cycles; completed bursts are
// queued in a ring of NUM_SLOTS slots and drained in order over rd.
module ddr2_read_capture_fifo #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int NUM_SLOTS = 4,
  parameter int CAP_DELAY = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           listen,
  input  logic                           flush,
  input  logic                           clr_err,
  input  logic [DATA_W-1:0]              din,
  ddr2_read_capture_fifo_if.master       rd,
  output logic                           busy,
  output logic [$clog2(NUM_SLOTS+1)-1:0] slots_used,
  output logic                           err_drop
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [3:0]    START_CNT = 4'(CAP_DELAY);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t            state, state_n;
  logic [3:0]        delay_cnt, delay_cnt_n;
  logic [BW-1:0]     beat, beat_n;
  logic [SW-1:0]     wr_slot, rd_slot;
  logic [BW-1:0]     rd_beat;
  logic [DATA_W-1:0] mem [NUM_SLOTS][BURST_LEN];
  logic [CW:0]       occupancy;
  logic              at_last_beat, can_start, accept, drop;
  logic              commit, fire, slot_release;

  assign busy         = (state != IDLE);
  assign at_last_beat = (state == CAPTURE) && (beat == LAST_BEAT);
  // The engine's in-flight burst reserves a slot, so a drain in the same
  // cycle cannot make room for a new listen.
  assign occupancy    = {1'b0, slots_used} + (CW+1)'(busy);
  assign can_start    = (state == IDLE) || at_last_beat;
  assign accept       = listen && !flush && can_start &&
                        (occupancy < (CW+1)'(NUM_SLOTS));
  assign drop         = listen && !flush && !accept;
  assign commit       = at_last_beat && !flush;

  assign rd.dout_valid = (slots_used != '0);
  assign rd.dout       = mem[rd_slot][rd_beat];
  assign rd.dout_last  = rd.dout_valid && (rd_beat == LAST_BEAT);
  assign fire          = rd.dout_valid && rd.dout_ready && !flush;
  assign slot_release  = fire && (rd_beat == LAST_BEAT);

  // Capture FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      delay_cnt <= '0;
      beat      <= '0;
    end else begin
      state     <= state_n;
      delay_cnt <= delay_cnt_n;
      beat      <= beat_n;
    end
  end

  // Capture FSM next state; a listen on the final beat restarts without a gap
  always_comb begin
    state_n     = state;
    delay_cnt_n = delay_cnt;
    beat_n      = beat;
    if (flush) begin
      state_n     = IDLE;
      delay_cnt_n = '0;
      beat_n      = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (CAP_DELAY == 0) begin
              state_n = CAPTURE;
            end else begin
              state_n     = WAIT;
              delay_cnt_n = START_CNT;
            end
          end
        end
        WAIT: begin
          if (delay_cnt <= 4'd1) begin
            state_n     = CAPTURE;
            delay_cnt_n = '0;
          end else begin
            delay_cnt_n = delay_cnt - 4'd1;
          end
        end
        CAPTURE: begin
          if (beat == LAST_BEAT) begin
            beat_n = '0;
            if (!accept) begin
              state_n = IDLE;
            end else if (CAP_DELAY == 0) begin
              state_n = CAPTURE;
            end else begin
              state_n     = WAIT;
              delay_cnt_n = START_CNT;
            end
          end else begin
            beat_n = beat + BW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Burst storage; contents survive flush and are only zeroed by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        for (int b = 0; b < BURST_LEN; b++) begin
          mem[s][b] <= '0;
        end
      end
    end else if ((state == CAPTURE) && !flush) begin
      mem[wr_slot][beat] <= din;
    end
  end

  // Ring pointers and slot count; commit and release together cancel out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_slot    <= '0;
      rd_slot    <= '0;
      rd_beat    <= '0;
      slots_used <= '0;
    end else if (flush) begin
      wr_slot    <= '0;
      rd_slot    <= '0;
      rd_beat    <= '0;
      slots_used <= '0;
    end else begin
      if (commit) begin
        wr_slot <= wr_slot + SW'(1);
      end
      if (fire) begin
        rd_beat <= slot_release ? '0 : rd_beat + BW'(1);
      end
      if (slot_release) begin
        rd_slot <= rd_slot + SW'(1);
      end
      if (commit && !slot_release) begin
        slots_used <= slots_used + CW'(1);
      end else if (!commit && slot_release) begin
        slots_used <= slots_used - CW'(1);
      end
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_drop <= 1'b0;
    end else if (drop) begin
      err_drop <= 1'b1;
    end else if (clr_err) begin
      err_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr2_read_capture_fifo.sv
// Bench for ddr2_read_capture_fifo: a default-parameter instance checked
// against a word-queue reference model, plus a CAP_DELAY=3 instance.
module tb_ddr2_read_capture_fifo;

  localparam int DW  = 16;
  localparam int BL  = 8;
  localparam int NS  = 4;
  localparam int CD0 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          listen, flush, clr_err;
  logic [DW-1:0] din;
  logic          busy, err_drop;
  logic [2:0]    slots_used;

  logic          listen1, flush1, clr1;
  logic [DW-1:0] din1;
  logic          busy1, err1;
  logic [2:0]    slots1;

  ddr2_read_capture_fifo_if #(.DATA_W(DW)) rd0 ();
  ddr2_read_capture_fifo_if #(.DATA_W(DW)) rd1 ();

  ddr2_read_capture_fifo #(.DATA_W(DW), .BURST_LEN(BL), .NUM_SLOTS(NS), .CAP_DELAY(0)) dut (
    .clk(clk), .reset_n(reset_n), .listen(listen), .flush(flush), .clr_err(clr_err),
    .din(din), .rd(rd0), .busy(busy), .slots_used(slots_used), .err_drop(err_drop));

  ddr2_read_capture_fifo #(.DATA_W(DW), .BURST_LEN(BL), .NUM_SLOTS(NS), .CAP_DELAY(3)) dut_d3 (
    .clk(clk), .reset_n(reset_n), .listen(listen1), .flush(flush1), .clr_err(clr1),
    .din(din1), .rd(rd1), .busy(busy1), .slots_used(slots1), .err_drop(err1));

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] cur[$];
  logic [DW-1:0] exp_w[$];
  bit m_active, m_err;
  int m_n, m_acc, m_last;

  // Reference model: completed words form one queue; a burst occupies a slot
  // until its last word leaves, so slot count is the word count rounded up.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      cur.delete();
      m_active = 0;
      m_err    = 0;
      m_n      = 0;
    end else begin
      bit pre_busy, at_final, m_drop;
      int pre_used;
      pre_busy = m_active;
      at_final = m_active && (m_n == m_last);
      pre_used = (mq.size() + BL - 1) / BL;
      m_drop   = 0;
      if (flush) begin
        mq.delete();
        cur.delete();
        m_active = 0;
      end else begin
        if (mq.size() > 0 && rd0.dout_ready) void'(mq.pop_front());
        if (m_active && m_n >= m_acc + 1 + CD0) begin
          cur.push_back(din);
          if (m_n == m_last) begin
            foreach (cur[i]) mq.push_back(cur[i]);
            cur.delete();
            m_active = 0;
          end
        end
        if (listen) begin
          if ((!pre_busy || at_final) && (pre_used + int'(pre_busy) < NS)) begin
            m_active = 1;
            m_acc    = m_n;
            m_last   = m_n + BL + CD0;
          end else begin
            m_drop = 1;
          end
        end
      end
      if (m_drop) m_err = 1;
      else if (clr_err) m_err = 0;
      m_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    listen = 0; flush = 0; clr_err = 0; din = '0; rd0.dout_ready = 0;
    listen1 = 0; flush1 = 0; clr1 = 0; din1 = '0; rd1.dout_ready = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rd0.dout_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", rd0.dout_valid); else passed++;
    total++; if (rd0.dout !== 16'h0) $display("[TB] FAIL reset_dout got %h want 0000", rd0.dout); else passed++;
    total++; if (rd0.dout_last !== 1'b0) $display("[TB] FAIL reset_last got %b want 0", rd0.dout_last); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (slots_used !== 3'd0) $display("[TB] FAIL reset_slots got %0d want 0", slots_used); else passed++;
    total++; if (err_drop !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", err_drop); else passed++;
  endtask

  task automatic test_single_burst();
    do_reset();
    listen = 1; din = 16'h1000;
    tick();
    listen = 0;
    for (int k = 1; k <= 8; k++) begin
      din = 16'h1000 + 16'(k);
      tick();
    end
    total++; if (rd0.dout_valid !== 1'b1) $display("[TB] FAIL single_valid got %b want 1", rd0.dout_valid); else passed++;
    total++; if (slots_used !== 3'd1) $display("[TB] FAIL single_slots got %0d want 1", slots_used); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL single_busy got %b want 0", busy); else passed++;
    rd0.dout_ready = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if (rd0.dout !== 16'h1001 + 16'(i)) $display("[TB] FAIL single_word%0d got %h want %h", i, rd0.dout, 16'h1001 + 16'(i)); else passed++;
      total++; if (rd0.dout_last !== (i == 7)) $display("[TB] FAIL single_last%0d got %b want %b", i, rd0.dout_last, (i == 7)); else passed++;
      tick();
    end
    rd0.dout_ready = 0;
    total++; if (slots_used !== 3'd0) $display("[TB] FAIL single_slots_end got %0d want 0", slots_used); else passed++;
    total++; if (rd0.dout_valid !== 1'b0) $display("[TB] FAIL single_valid_end got %b want 0", rd0.dout_valid); else passed++;
  endtask

  task automatic test_cap_delay();
    do_reset();
    listen1 = 1; din1 = 16'h2000;
    tick();
    listen1 = 0;
    total++; if (busy1 !== 1'b1) $display("[TB] FAIL delay_busy0 got %b want 1", busy1); else passed++;
    for (int k = 1; k <= 11; k++) begin
      din1 = 16'h2000 + 16'(k);
      tick();
      total++; if (busy1 !== (k < 11)) $display("[TB] FAIL delay_busy%0d got %b want %b", k, busy1, (k < 11)); else passed++;
    end
    total++; if (slots1 !== 3'd1) $display("[TB] FAIL delay_slots got %0d want 1", slots1); else passed++;
    rd1.dout_ready = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if (rd1.dout !== 16'h2004 + 16'(i)) $display("[TB] FAIL delay_word%0d got %h want %h", i, rd1.dout, 16'h2004 + 16'(i)); else passed++;
      tick();
    end
    rd1.dout_ready = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_w.delete();
    for (int k = 0; k <= 16; k++) begin
      din = 16'($urandom);
      if (k >= 1) exp_w.push_back(din);
      listen = (k == 0 || k == 8);
      tick();
      total++; if (busy !== (k < 16)) $display("[TB] FAIL b2b_busy%0d got %b want %b", k, busy, (k < 16)); else passed++;
    end
    listen = 0;
    total++; if (slots_used !== 3'd2) $display("[TB] FAIL b2b_slots got %0d want 2", slots_used); else passed++;
    total++; if (err_drop !== 1'b0) $display("[TB] FAIL b2b_err got %b want 0", err_drop); else passed++;
    rd0.dout_ready = 1;
    for (int i = 0; i < 16; i++) begin
      total++; if (rd0.dout !== exp_w[i]) $display("[TB] FAIL b2b_word%0d got %h want %h", i, rd0.dout, exp_w[i]); else passed++;
      total++; if (rd0.dout_last !== (i % 8 == 7)) $display("[TB] FAIL b2b_last%0d got %b want %b", i, rd0.dout_last, (i % 8 == 7)); else passed++;
      tick();
    end
    rd0.dout_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      din = 16'($urandom);
      listen = (k % 8 == 0);
      tick();
    end
    listen = 0;
    total++; if (err_drop !== 1'b1) $display("[TB] FAIL ovf_err got %b want 1", err_drop); else passed++;
    total++; if (slots_used !== 3'd4) $display("[TB] FAIL ovf_slots got %0d want 4", slots_used); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL ovf_busy got %b want 0", busy); else passed++;
    listen = 1; clr_err = 1;
    tick();
    listen = 0; clr_err = 0;
    total++; if (err_drop !== 1'b1) $display("[TB] FAIL ovf_setwins got %b want 1", err_drop); else passed++;
    total++; if (slots_used !== 3'd4) $display("[TB] FAIL ovf_slots2 got %0d want 4", slots_used); else passed++;
    flush = 1;
    tick();
    flush = 0;
    total++; if (err_drop !== 1'b1) $display("[TB] FAIL ovf_flush_err got %b want 1", err_drop); else passed++;
    total++; if (slots_used !== 3'd0) $display("[TB] FAIL ovf_flush_slots got %0d want 0", slots_used); else passed++;
    clr_err = 1;
    tick();
    clr_err = 0;
    total++; if (err_drop !== 1'b0) $display("[TB] FAIL ovf_clr got %b want 0", err_drop); else passed++;
  endtask

  task automatic test_mid_burst_drop();
    do_reset();
    exp_w.delete();
    for (int k = 0; k <= 8; k++) begin
      din = 16'($urandom);
      if (k >= 1) exp_w.push_back(din);
      listen = (k == 0 || k == 4);
      tick();
      if (k == 4) begin
        total++; if (err_drop !== 1'b1) $display("[TB] FAIL mid_err got %b want 1", err_drop); else passed++;
      end
    end
    listen = 0;
    total++; if (slots_used !== 3'd1) $display("[TB] FAIL mid_slots got %0d want 1", slots_used); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy got %b want 0", busy); else passed++;
    rd0.dout_ready = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if (rd0.dout !== exp_w[i]) $display("[TB] FAIL mid_word%0d got %h want %h", i, rd0.dout, exp_w[i]); else passed++;
      tick();
    end
    rd0.dout_ready = 0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k <= 22; k++) begin
      din = 16'($urandom);
      listen = (k % 8 == 0) && (k <= 16);
      flush = (k == 22);
      tick();
    end
    listen = 0; flush = 0;
    total++; if (busy !== 1'b0) $display("[TB] FAIL flush_busy got %b want 0", busy); else passed++;
    total++; if (slots_used !== 3'd0) $display("[TB] FAIL flush_slots got %0d want 0", slots_used); else passed++;
    total++; if (rd0.dout_valid !== 1'b0) $display("[TB] FAIL flush_valid got %b want 0", rd0.dout_valid); else passed++;
    exp_w.delete();
    for (int k = 0; k <= 8; k++) begin
      din = 16'($urandom);
      if (k >= 1) exp_w.push_back(din);
      listen = (k == 0);
      tick();
    end
    listen = 0;
    total++; if (slots_used !== 3'd1) $display("[TB] FAIL flush_new_slots got %0d want 1", slots_used); else passed++;
    rd0.dout_ready = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if (rd0.dout !== exp_w[i]) $display("[TB] FAIL flush_word%0d got %h want %h", i, rd0.dout, exp_w[i]); else passed++;
      tick();
    end
    rd0.dout_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      din = 16'($urandom);
      listen = (k == 0 || k == 8);
      tick();
    end
    listen = 0;
    rd0.dout_ready = 1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (rd0.dout_valid !== 1'b0) $display("[TB] FAIL rmid_valid got %b want 0", rd0.dout_valid); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rmid_busy got %b want 0", busy); else passed++;
    total++; if (slots_used !== 3'd0) $display("[TB] FAIL rmid_slots got %0d want 0", slots_used); else passed++;
    total++; if (rd0.dout !== 16'h0) $display("[TB] FAIL rmid_dout got %h want 0000", rd0.dout); else passed++;
    #1;
    reset_n = 1'b1;
    rd0.dout_ready = 0;
    tick();
    total++; if (slots_used !== 3'd0) $display("[TB] FAIL rmid_after got %0d want 0", slots_used); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      listen = ($urandom_range(0, 5) == 0);
      rd0.dout_ready = ($urandom_range(0, 2) != 0);
      din = 16'($urandom);
      clr_err = ($urandom_range(0, 15) == 0);
      flush = ($urandom_range(0, 60) == 0);
      tick();
      total++; if (rd0.dout_valid !== (mq.size() > 0)) $display("[TB] FAIL rnd_valid c%0d got %b want %b", c, rd0.dout_valid, (mq.size() > 0)); else passed++;
      total++; if (slots_used !== 3'((mq.size() + BL - 1) / BL)) $display("[TB] FAIL rnd_slots c%0d got %0d want %0d", c, slots_used, (mq.size() + BL - 1) / BL); else passed++;
      total++; if (rd0.dout_last !== (mq.size() % BL == 1)) $display("[TB] FAIL rnd_last c%0d got %b want %b", c, rd0.dout_last, (mq.size() % BL == 1)); else passed++;
      total++; if (busy !== m_active) $display("[TB] FAIL rnd_busy c%0d got %b want %b", c, busy, m_active); else passed++;
      total++; if (err_drop !== m_err) $display("[TB] FAIL rnd_err c%0d got %b want %b", c, err_drop, m_err); else passed++;
      if (mq.size() > 0) begin
        total++; if (rd0.dout !== mq[0]) $display("[TB] FAIL rnd_dout c%0d got %h want %h", c, rd0.dout, mq[0]); else passed++;
      end
    end
    listen = 0; flush = 0; clr_err = 0; rd0.dout_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_cap_delay();
    test_back_to_back();
    test_overflow();
    test_mid_burst_drop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
